// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state, opcode, ALU and mux-select encodings for the multicycle control FSM
package multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_M, S_EXEC_B, S_MEM, S_WB_R, S_WB_M, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;
  localparam logic [1:0] SB_RS2 = 2'b00;
  localparam logic [1:0] SB_4   = 2'b01;
  localparam logic [1:0] SB_IMM = 2'b10;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_alu_ctl_dec.sv
// multicycle_ctrl_alu_ctl_dec: maps R-type {funct7_5,funct3} to an ALU operation and flags unsupported encodings
module multicycle_ctrl_alu_ctl_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic       funct7_5,
  input  logic [2:0] funct3,
  output logic [3:0] alu_op,
  output logic       illegal
);
  // only add/sub/and/or are supported; anything else is reported illegal with a harmless ADD
  always_comb begin
    alu_op = ALU_ADD;
    illegal = 1'b0;
    case ({funct7_5, funct3})
      4'b0000: alu_op = ALU_ADD;
      4'b1000: alu_op = ALU_SUB;
      4'b0111: alu_op = ALU_AND;
      4'b0110: alu_op = ALU_OR;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the shared multicycle RV64 datapath with memory timeout trap and instret counter
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  state_t state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [TW-1:0] tmo_q;
  logic [CNT_W-1:0] instret_q;
  logic [3:0] r_op;
  logic r_ill, tmo_hit, retire;

  multicycle_ctrl_alu_ctl_dec u_dec (
    .funct7_5 (funct7_5),
    .funct3   (funct3),
    .alu_op   (r_op),
    .illegal  (r_ill)
  );

  // the wait that would be the MEM_TIMEOUT-th consecutive one traps instead; a ready in that cycle wins
  assign tmo_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (tmo_q == TW'(MEM_TIMEOUT - 1));
  assign retire = (state_q == S_EXEC_B) || (state_q == S_WB_R) || (state_q == S_WB_M) ||
                  (state_q == S_MEM && mem_ready && opcode == OP_SD);

  // next-state: instruction sequencing, illegal-instruction and timeout traps
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_R) state_d = S_EXEC_R;
        else if ((opcode == OP_LD || opcode == OP_SD) && funct3 == F3_D) state_d = S_EXEC_M;
        else if (opcode == OP_BR && funct3 == F3_BEQ) state_d = S_EXEC_B;
        else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EXEC_R: begin
        state_d = r_ill ? S_TRAP : S_WB_R;
        cause_d = r_ill ? CAUSE_ILL : cause_q;
      end
      S_EXEC_M: state_d = S_MEM;
      S_MEM:    state_d = !mem_ready ? S_MEM : (opcode == OP_SD) ? S_FETCH : S_WB_M;
      S_EXEC_B, S_WB_R, S_WB_M: state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
    if (tmo_hit) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TMO;
    end
  end

  // state, trap cause, consecutive-wait counter and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      tmo_q <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tmo_q <= (mem_req && !mem_ready && !tmo_hit) ? tmo_q + 1'b1 : '0;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end

  assign mem_req    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we     = (state_q == S_MEM) && (opcode == OP_SD);
  assign iord       = (state_q == S_MEM);
  assign ir_write   = (state_q == S_FETCH) && mem_ready;
  assign pc_write   = ((state_q == S_FETCH) && mem_ready) || ((state_q == S_EXEC_B) && alu_zero);
  assign pc_src     = (state_q == S_EXEC_B);
  assign alu_src_a  = (state_q == S_DECODE) ? SA_OLDPC :
                      (state_q == S_EXEC_R || state_q == S_EXEC_M || state_q == S_EXEC_B) ? SA_RS1 : SA_PC;
  assign alu_src_b  = (state_q == S_FETCH) ? SB_4 :
                      (state_q == S_DECODE || state_q == S_EXEC_M) ? SB_IMM : SB_RS2;
  assign alu_op     = (state_q == S_FETCH || state_q == S_DECODE || state_q == S_EXEC_M) ? ALU_ADD :
                      (state_q == S_EXEC_R) ? r_op : (state_q == S_EXEC_B) ? ALU_SUB : '0;
  assign reg_write  = (state_q == S_WB_R) || (state_q == S_WB_M);
  assign mem_to_reg = (state_q == S_WB_M);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked cycle by cycle against a per-instruction timeline model
module tb_multicycle_ctrl;
  localparam int TMO = 4;
  localparam int CW = 4;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_OP = 4'b0000, OR_OP = 4'b0001;
  localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, SD = 7'b0100011, BR = 7'b1100011;

  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic [1:0] a, b;
    logic [3:0] op;
    logic rw, m2r, trap;
    logic [1:0] cause;
  } ov_t;
  typedef struct packed {
    logic rdy, chk, ret;
    ov_t o;
  } step_t;

  logic clk = 0, reset = 0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 0, alu_zero = 0, mem_ready = 0;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg, trap;
  logic [1:0] alu_src_a, alu_src_b, trap_cause;
  logic [3:0] alu_op;
  logic [CW-1:0] instret;
  ov_t dut_v;
  step_t q[$];
  int n_vec = 0, n_err = 0, cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  assign dut_v = ov_t'({mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                        alu_op, reg_write, mem_to_reg, trap, trap_cause});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(input logic rdy, input ov_t o, input logic ch, input logic rt);
    q.push_back(step_t'({rdy, ch, rt, o}));
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 0;
    mem_ready = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset_out", 32'(dut_v), 32'd0);
      chk("reset_instret", 32'(instret), 32'd0);
    end
    reset = 1;
    cnt = 0;
  endtask

  // expected cycle-by-cycle timeline of one instruction, built from the instruction's class and wait counts
  task automatic plan(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic z,
                      input int wf, input int wm, output logic [1:0] cause);
    ov_t o;
    logic [3:0] rop;
    logic leg;
    q.delete();
    cause = 2'b00;
    o = '0; o.mem_req = 1; o.b = 2'b01; o.op = ADD;
    for (int i = 0; i < wf && i < TMO; i++) add(1'b0, o, 1'b1, 1'b0);
    if (wf >= TMO) begin cause = 2'b10; return; end
    o.ir_write = 1; o.pc_write = 1;
    add(1'b1, o, 1'b1, 1'b0);
    o = '0; o.a = 2'b01; o.b = 2'b10; o.op = ADD;
    add(1'($urandom), o, 1'b1, 1'b0);
    if (opc == R) begin
      leg = 1; rop = ADD;
      case ({f7, f3})
        4'b0000: rop = ADD;
        4'b1000: rop = SUB;
        4'b0111: rop = AND_OP;
        4'b0110: rop = OR_OP;
        default: leg = 0;
      endcase
      o = '0; o.a = 2'b10; o.b = 2'b00; o.op = rop;
      add(1'($urandom), o, leg, 1'b0);
      if (!leg) begin cause = 2'b01; return; end
      o = '0; o.rw = 1;
      add(1'($urandom), o, 1'b1, 1'b1);
    end else if ((opc == LD || opc == SD) && f3 == 3'b011) begin
      o = '0; o.a = 2'b10; o.b = 2'b10; o.op = ADD;
      add(1'($urandom), o, 1'b1, 1'b0);
      o = '0; o.mem_req = 1; o.iord = 1; o.mem_we = (opc == SD);
      for (int i = 0; i < wm && i < TMO; i++) add(1'b0, o, 1'b1, 1'b0);
      if (wm >= TMO) begin cause = 2'b10; return; end
      add(1'b1, o, 1'b1, opc == SD);
      if (opc == LD) begin
        o = '0; o.rw = 1; o.m2r = 1;
        add(1'($urandom), o, 1'b1, 1'b1);
      end
    end else if (opc == BR && f3 == 3'b000) begin
      o = '0; o.a = 2'b10; o.b = 2'b00; o.op = SUB; o.pc_src = 1; o.pc_write = z;
      add(1'($urandom), o, 1'b1, 1'b1);
    end else cause = 2'b01;
  endtask

  task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic z,
                     input int wf, input int wm, input int cut);
    logic [1:0] cause;
    ov_t o;
    step_t s;
    plan(opc, f3, f7, z, wf, wm, cause);
    if (cause != 2'b00) begin
      o = '0; o.trap = 1; o.cause = cause;
      for (int i = 0; i < 3; i++) add(1'($urandom), o, 1'b1, 1'b0);
    end
    for (int i = 0; i < q.size() && i < cut; i++) begin
      s = q[i];
      @(negedge clk);
      opcode = opc; funct3 = f3; funct7_5 = f7; alu_zero = z; mem_ready = s.rdy;
      #1;
      if (s.chk) chk("outputs", 32'(dut_v), 32'(s.o));
      chk("instret", 32'(instret), 32'(cnt % (1 << CW)));
      if (s.ret) cnt++;
    end
    if (cause != 2'b00 || cut < q.size()) do_reset;
  endtask

  initial begin
    logic [6:0] opc;
    logic [2:0] f3;
    logic f7;
    int k, p;
    do_reset;
    run(R, 3'b000, 1'b0, 1'b0, 0, 0, 99);
    run(LD, 3'b011, 1'b0, 1'b0, 0, 3, 99);
    run(BR, 3'b000, 1'b0, 1'b1, 0, 0, 99);
    run(BR, 3'b000, 1'b0, 1'b0, 0, 0, 99);
    run(SD, 3'b011, 1'b0, 1'b0, 2, 3, 99);
    run(R, 3'b000, 1'b1, 1'b0, 3, 0, 99);
    run(R, 3'b111, 1'b1, 1'b0, 0, 0, 99);
    run(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0, 99);
    run(R, 3'b110, 1'b0, 1'b0, TMO, 0, 99);
    run(LD, 3'b011, 1'b0, 1'b0, 0, TMO, 99);
    run(LD, 3'b011, 1'b0, 1'b0, 0, 2, 4);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      f7 = 1'b0;
      if (k < 3) begin
        opc = R;
        p = $urandom_range(0, 4);
        {f7, f3} = (p == 0) ? 4'b0000 : (p == 1) ? 4'b1000 : (p == 2) ? 4'b0111 :
                   (p == 3) ? 4'b0110 : 4'($urandom);
      end else if (k < 5) begin opc = LD; f3 = 3'b011; end
      else if (k < 7) begin opc = SD; f3 = 3'b011; end
      else if (k < 9) begin opc = BR; f3 = 3'b000; end
      else begin opc = 7'($urandom); f3 = 3'($urandom); f7 = 1'($urandom); end
      run(opc, f3, f7, 1'($urandom),
          ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3),
          ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3),
          ($urandom_range(0, 29) == 0) ? $urandom_range(1, 4) : 99);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
